// File: rtl/ahbl_mem_slv_if.sv
// AHB-Lite link between one initiator and the memory responder.
// Signal names follow the responder's view of the bus.
interface ahbl_mem_slv_if #(
   parameter int AW = 32,
   parameter int RW = 32
);
   logic          i_HSel;
   logic [AW-1:0] i_HAddr;
   logic [1:0]    i_HTrans;
   logic [2:0]    i_HSize;
   logic [2:0]    i_HBurst;
   logic          i_HWrite;
   logic [RW-1:0] i_HWdata;
   logic          i_HReadyIn;
   logic          o_HReadyOut;
   logic [1:0]    o_HResp;
   logic [RW-1:0] o_HRdata;

   modport slave (
      input  i_HSel, i_HAddr, i_HTrans, i_HSize, i_HBurst, i_HWrite, i_HWdata, i_HReadyIn,
      output o_HReadyOut, o_HResp, o_HRdata
   );

   modport master (
      output i_HSel, i_HAddr, i_HTrans, i_HSize, i_HBurst, i_HWrite, i_HWdata, i_HReadyIn,
      input  o_HReadyOut, o_HResp, o_HRdata
   );
endinterface

// File: rtl/ahbl_mem_slv.sv
// AHB-Lite responder backed by a 2^MW-word memory; WAIT wait states per OKAY
// transfer (WAIT+1 cycles accept-to-done), two-cycle ERROR, stalls via o_HReadyOut.
module ahbl_mem_slv #(
   parameter int AW   = 32,
   parameter int RW   = 32,
   parameter int MW   = 8,
   parameter int WAIT = 0
) (
   input  logic          i_HClk,
   input  logic          i_RstN,
   ahbl_mem_slv_if.slave bus
);
   localparam int NL = RW / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAITS = 3'd1,
      S_DATA  = 3'd2,
      S_ERR1  = 3'd3,
      S_ERR2  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [MW+1:0]   addr_q;
   logic [1:0]      size_q;
   logic            wr_q;
   logic            accept;
   logic            acc_err;
   logic [NL-1:0]   lane_en;
   logic [RW-1:0]   mem_q [2**MW];

   logic unused_bits;
   assign unused_bits = &{1'b0, bus.i_HBurst, bus.i_HTrans[0]};

   // Only states whose HREADYOUT is high may take a new address phase.
   always_comb begin
      accept = bus.i_HSel & bus.i_HTrans[1] & bus.i_HReadyIn &
               ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));
      acc_err = (bus.i_HSize > 3'd2) |
                ((bus.i_HSize == 3'd1) & bus.i_HAddr[0]) |
                ((bus.i_HSize == 3'd2) & (bus.i_HAddr[1:0] != 2'b00)) |
                ((bus.i_HAddr >> (MW + 2)) != '0);
   end

   always_ff @(posedge i_HClk or negedge i_RstN) begin
      if (!i_RstN) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         size_q  <= 2'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= bus.i_HAddr[MW+1:0];
            size_q <= bus.i_HSize[1:0];
            wr_q   <= bus.i_HWrite;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            state_d = S_IDLE;
            if (accept) begin
               if (acc_err) begin
                  state_d = S_ERR1;
               end else if (WAIT > 0) begin
                  state_d = S_WAITS;
                  cnt_d   = 3'(WAIT);
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_WAITS: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_DATA;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_HReadyOut = !((state_q == S_WAITS) || (state_q == S_ERR1));
      bus.o_HResp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
      bus.o_HRdata    = ((state_q == S_DATA) && !wr_q) ? mem_q[addr_q[MW+1:2]] : '0;
   end

   // Alignment was enforced at accept, so lanes never straddle the word.
   always_comb begin
      case (size_q)
         2'd0:    lane_en = 4'b0001 << addr_q[1:0];
         2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   always_ff @(posedge i_HClk) begin
      if ((state_q == S_DATA) && wr_q) begin
         for (int i = 0; i < NL; i++) begin
            if (lane_en[i]) mem_q[addr_q[MW+1:2]][8*i +: 8] <= bus.i_HWdata[8*i +: 8];
         end
      end
   end
endmodule
